gf_syndrome_bank: RTL and testbench
===================================

GF_SYNDROME_BANK -- requirements
Module: gf_syndrome_bank

Interface
REQ-001 Parameter M, default 5, GF(2^M) symbol width in bits; bit i of every symbol is the coefficient of x^i.
REQ-002 Parameter N, default 4, number of independent accumulator channels.
REQ-003 Parameter POLY, default 5'b00101, low M bits of the primitive polynomial (x^5+x^2+1).
REQ-004 Parameter CW, default 5, width of the block-length counter.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  begin a block; sampled in IDLE only.
REQ-009 len  in  CW  symbols per block; sampled with start.
REQ-010 load  in  1  preload accumulators from init; sampled in IDLE only.
REQ-011 init  in  N*M  preload values; channel i occupies bits [i*M +: M].
REQ-012 coef  in  N*M  per-channel multiplier; channel i occupies bits [i*M +: M].
REQ-013 data  in  M  incoming symbol, shared by all channels.
REQ-014 in_valid  in  1  data is valid this cycle.
REQ-015 in_ready  out  1  block accepts data this cycle.
REQ-016 acc_out  out  N*M  accumulator contents, registered.
REQ-017 done  out  1  one-cycle pulse at block completion.
REQ-018 busy  out  1  high in RUN and DONE.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE, with busy = (state != IDLE).
REQ-020 IDLE, start=1 and load=0: acc <= 0, cnt <= 0, len latched; next state RUN, or DONE if len==0.
REQ-021 IDLE, start=1 and load=1: acc <= init, cnt <= 0, len latched; the next state is chosen as in REQ-020.
REQ-022 IDLE, load=1 and start=0: acc <= init; the state stays IDLE.
REQ-023 IDLE with neither start nor load asserted: acc holds.
REQ-024 in_ready SHALL be 1 only in RUN; it is combinational from state.
REQ-025 RUN, in_valid=1: for every channel i, acc[i] <= gfmul(acc[i], coef[i]) XOR data, and cnt <= cnt+1.
REQ-026 RUN, in_valid=0: acc and cnt hold; gaps of any length are legal.
REQ-027 RUN: when a symbol is accepted with cnt == latched len-1, the next state is DONE.
REQ-028 start and load SHALL be ignored in RUN and DONE.
REQ-029 DONE: done=1 for exactly one cycle, acc holds, and the next state is IDLE unconditionally.
REQ-030 acc_out SHALL equal acc; an accepted symbol is visible on acc_out the cycle after acceptance.
REQ-031 done SHALL rise the cycle after the last symbol is accepted.
REQ-032 gfmul SHALL be a full GF(2^M) polynomial-basis product reduced modulo x^M + POLY.
REQ-033 cnt SHALL be CW bits wide; the block supports lengths 0 to 2^CW-1 without wrap-around.

Reset
REQ-034 On reset=1 at a clock edge: state IDLE, all acc 0, cnt 0, done 0, and latched len 0.
REQ-035 Reset SHALL override every other input, including mid-RUN; no done pulse is produced for an aborted block.
REQ-036 After reset: in_ready=0, busy=0, done=0 and acc_out=0.

Structure
REQ-037 The state encoding and the default M and POLY values SHALL live in the shared GF package, gf_pkg.
REQ-038 One sub-module, gf_mult_param (parameters M and POLY, purely combinational), SHALL be instantiated N times.
REQ-039 No other sub-modules are used; counter and FSM stay in gf_syndrome_bank.

Verification
REQ-040 Horner check: N=1, coef=5'b00010, start with len=3, data 1,0,0 back-to-back -> acc_out 00001, 00010, 00100; done one cycle after the third accept.
REQ-041 Reduction check: coef=00010, len=6, data 1 then five 0s -> final acc_out=00101 (alpha^5).
REQ-042 Gaps: repeat REQ-040 with in_valid low for 2 cycles between symbols -> identical acc_out sequence; done only after the third accept.
REQ-043 len=0 and load: start with len=0 and load=1, init=5'b10101 -> DONE next cycle, done=1, acc_out=10101, no in_ready pulse.
REQ-044 Mid-RUN reset: reset after 2 of 4 symbols -> next cycle IDLE, acc_out=0; no done pulse; a following start runs normally.
REQ-045 Multi-channel: N=4, coef=alpha^1..alpha^4, 31-symbol codeword of all zeros except data=1 at symbol 0 -> acc[i]=alpha^(30*(i+1)).

Source files
------------

// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions for the syndrome accumulator bank.
//   GF_M     : default symbol width in bits
//   GF_POLY  : default low M bits of the primitive polynomial (x^5 + x^2 + 1)
//   state_e  : control FSM encoding used by gf_syndrome_bank
package gf_pkg;

  localparam int         GF_M    = 5;
  localparam logic [4:0] GF_POLY = 5'b00101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gf_mult_param.sv
// Purely combinational GF(2^M) multiplier, polynomial basis.
// The product is reduced modulo x^M + POLY.
// Ports:
//   a, b : input  [M-1:0]  operands (bit i = coefficient of x^i)
//   p    : output [M-1:0]  a * b in GF(2^M)
module gf_mult_param
  import gf_pkg::*;
#(
  parameter int         M    = GF_M,
  parameter logic [M-1:0] POLY = M'(GF_POLY)
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] sum;
  logic [M-1:0] a_sh;

  // Shift-and-add: a_sh walks through a*x^i (already reduced), and the
  // terms selected by b are XOR-accumulated.
  always_comb begin
    sum  = '0;
    a_sh = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) sum = sum ^ a_sh;
      a_sh = {a_sh[M-2:0], 1'b0} ^ (a_sh[M-1] ? POLY : '0);
    end
    p = sum;
  end

endmodule

// File: rtl/gf_syndrome_bank.sv
// Bank of N GF(2^M) Horner accumulators sharing one input symbol stream.
// Each accepted symbol updates acc[i] <= acc[i]*coef[i] ^ data.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start, len   : begin a block of len symbols (sampled in IDLE)
//   load, init   : preload accumulators from init (sampled in IDLE)
//   coef         : per-channel multiplier, channel i at [i*M +: M]
//   data         : shared input symbol, in_valid qualifies it
//   in_ready     : high only while a block is running
//   acc_out      : registered accumulator contents, channel i at [i*M +: M]
//   done         : one-cycle pulse after the last symbol of a block
//   busy         : high while a block is running or completing
module gf_syndrome_bank
  import gf_pkg::*;
#(
  parameter int           M    = GF_M,
  parameter int           N    = 4,
  parameter logic [M-1:0] POLY = M'(GF_POLY),
  parameter int           CW   = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [CW-1:0]  len,
  input  logic           load,
  input  logic [N*M-1:0] init,
  input  logic [N*M-1:0] coef,
  input  logic [M-1:0]   data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*M-1:0] acc_out,
  output logic           done,
  output logic           busy
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  len_q, len_d;
  logic [N*M-1:0] acc_q, acc_d;
  logic [N*M-1:0] prod;

  for (genvar g = 0; g < N; g++) begin : g_mul
    gf_mult_param #(
      .M    (M),
      .POLY (POLY)
    ) u_mul (
      .a (acc_q[g*M +: M]),
      .b (coef[g*M +: M]),
      .p (prod[g*M +: M])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = load ? init : '0;
          cnt_d   = '0;
          len_d   = len;
          // A zero-length block completes without ever accepting data.
          state_d = (len == '0) ? ST_DONE : ST_RUN;
        end else if (load) begin
          acc_d = init;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          acc_d = prod ^ {N{data}};
          cnt_d = cnt_q + CW'(1);
          // len_q >= 1 here, so len_q-1 cannot underflow.
          if (cnt_q == len_q - CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
    end
  end

  // DONE always lasts exactly one cycle, so done can come straight from state.
  assign in_ready = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign acc_out  = acc_q;

endmodule

// File: tb/tb_gf_syndrome_bank.sv
module tb_gf_syndrome_bank;

  localparam int           M     = 5;
  localparam int           N     = 4;
  localparam int           CW    = 5;
  localparam logic [M-1:0] POLYV = 5'b00101;

  logic           clock;
  logic           reset;
  logic           start;
  logic [CW-1:0]  len;
  logic           load;
  logic [N*M-1:0] init;
  logic [N*M-1:0] coef;
  logic [M-1:0]   data;
  logic           in_valid;
  logic           in_ready;
  logic [N*M-1:0] acc_out;
  logic           done;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // Reference accumulators and directed stimulus tables
  logic [M-1:0] ex   [N];
  logic [M-1:0] dat  [32];
  logic [M-1:0] seq0 [32];

  gf_syndrome_bank #(
    .M    (M),
    .N    (N),
    .POLY (POLYV),
    .CW   (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .load     (load),
    .init     (init),
    .coef     (coef),
    .data     (data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .done     (done),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full carry-less product followed by long division by x^M + POLY.
  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    logic [2*M-2:0] fp;
    p  = '0;
    fp = (2*M-1)'({1'b1, POLYV});
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ((2*M-1)'(a) << i);
    for (int k = 2*M-2; k >= M; k--)
      if (p[k]) p = p ^ (fp << (k - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] apow(input int e);
    logic [M-1:0] r;
    r = 1;
    for (int i = 0; i < e % 31; i++) r = gmul(r, 5'b00010);
    return r;
  endfunction

  function automatic logic [N*M-1:0] packex();
    logic [N*M-1:0] r;
    for (int i = 0; i < N; i++) r[i*M +: M] = ex[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_accept(input logic [N*M-1:0] cf, input logic [M-1:0] d);
    for (int i = 0; i < N; i++) ex[i] = gmul(ex[i], cf[i*M +: M]) ^ d;
  endtask

  // gmode: 0 back-to-back, 1 two idle cycles between symbols,
  //        2 random gaps with start/load noise that must be ignored.
  task automatic run_block(input int ln, input bit ld, input logic [N*M-1:0] iv,
                           input logic [N*M-1:0] cf, input int gmode,
                           input bit use_dat, input bit use_seq);
    int g;
    logic [M-1:0] d;
    start = 1'b1; load = ld; init = iv; len = CW'(ln); coef = cf; in_valid = 1'b0;
    tick();
    start = 1'b0; load = 1'b0;
    for (int i = 0; i < N; i++) ex[i] = ld ? iv[i*M +: M] : '0;
    if (ln == 0) begin
      chk("len0_done", 32'(done), 32'(1'b1));
      chk("len0_ready", 32'(in_ready), 32'(1'b0));
      chk("len0_acc", 32'(acc_out), 32'(packex()));
      tick();
      chk("len0_idle", 32'(busy), 32'(1'b0));
      chk("len0_ready2", 32'(in_ready), 32'(1'b0));
      return;
    end
    chk("start_ready", 32'(in_ready), 32'(1'b1));
    chk("start_busy", 32'(busy), 32'(1'b1));
    chk("start_acc", 32'(acc_out), 32'(packex()));
    for (int j = 0; j < ln; j++) begin
      g = (j == 0) ? 0 : (gmode == 1) ? 2 : (gmode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        data = M'($urandom);
        if (gmode == 2) begin
          start = 1'($urandom); load = 1'($urandom); init = (N*M)'($urandom);
          len = CW'($urandom);
        end
        tick();
        start = 1'b0; load = 1'b0;
        chk("gap_acc", 32'(acc_out), 32'(packex()));
        chk("gap_done", 32'(done), 32'(1'b0));
        chk("gap_ready", 32'(in_ready), 32'(1'b1));
      end
      d = use_dat ? dat[j] : M'($urandom);
      data = d; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      model_accept(cf, d);
      chk("acc", 32'(acc_out), 32'(packex()));
      if (use_seq) chk("acc_ch0_seq", 32'(acc_out[M-1:0]), 32'(seq0[j]));
      chk("done_timing", 32'(done), 32'(j == ln - 1));
    end
    // Noise during DONE must not start a new block.
    start = 1'b1; load = 1'b1; init = (N*M)'($urandom); len = CW'(3);
    tick();
    start = 1'b0; load = 1'b0;
    chk("post_done", 32'(done), 32'(1'b0));
    chk("post_busy", 32'(busy), 32'(1'b0));
    chk("post_acc", 32'(acc_out), 32'(packex()));
  endtask

  logic [N*M-1:0] cf_alpha;
  logic [N*M-1:0] rv;

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; load = 1'b0; init = '0;
    coef = '0; data = '0; in_valid = 1'b0;
    for (int i = 0; i < N; i++) ex[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_done", 32'(done), 32'(1'b0));
    chk("rst_acc", 32'(acc_out), 32'(0));

    // Load without start stays idle and takes init.
    rv = (N*M)'($urandom);
    load = 1'b1; init = rv;
    tick();
    load = 1'b0;
    for (int i = 0; i < N; i++) ex[i] = rv[i*M +: M];
    chk("load_acc", 32'(acc_out), 32'(rv));
    chk("load_busy", 32'(busy), 32'(1'b0));
    init = '0;
    tick();
    chk("idle_hold", 32'(acc_out), 32'(rv));

    // Horner with coef = alpha on every channel.
    cf_alpha = {N{5'b00010}};
    dat[0] = 5'd1; dat[1] = 5'd0; dat[2] = 5'd0;
    seq0[0] = 5'b00001; seq0[1] = 5'b00010; seq0[2] = 5'b00100;
    run_block(3, 1'b0, '0, cf_alpha, 0, 1'b1, 1'b1);
    run_block(3, 1'b0, '0, cf_alpha, 1, 1'b1, 1'b1);

    // Reduction: alpha^5 = x^2 + 1.
    dat[0] = 5'd1;
    for (int j = 1; j < 6; j++) dat[j] = 5'd0;
    run_block(6, 1'b0, '0, cf_alpha, 0, 1'b1, 1'b0);
    chk("reduce_alpha5", 32'(acc_out[M-1:0]), 32'(5'b00101));

    // Zero-length block with preload.
    run_block(0, 1'b1, {N{5'b10101}}, cf_alpha, 0, 1'b0, 1'b0);
    chk("len0_init", 32'(acc_out[M-1:0]), 32'(5'b10101));

    // Reset in the middle of a 4-symbol block.
    start = 1'b1; len = CW'(4); coef = (N*M)'($urandom);
    tick();
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      data = M'($urandom); in_valid = 1'b1;
      tick();
    end
    reset = 1'b1; data = M'($urandom);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < N; i++) ex[i] = '0;
    chk("mrst_acc", 32'(acc_out), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(1'b0));
    chk("mrst_ready", 32'(in_ready), 32'(1'b0));
    chk("mrst_done", 32'(done), 32'(1'b0));
    tick();
    chk("mrst_nodone", 32'(done), 32'(1'b0));
    run_block(2, 1'b0, '0, (N*M)'($urandom), 0, 1'b0, 1'b0);

    // Multi-channel impulse over a 31-symbol codeword.
    for (int i = 0; i < N; i++) cf_alpha[i*M +: M] = apow(i + 1);
    dat[0] = 5'd1;
    for (int j = 1; j < 31; j++) dat[j] = 5'd0;
    run_block(31, 1'b0, '0, cf_alpha, 0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++)
      chk("multi_ch", 32'(acc_out[i*M +: M]), 32'(apow(30 * (i + 1))));

    // Random blocks with gaps, preload and ignored control noise.
    for (int b = 0; b < 6; b++)
      run_block(int'($urandom_range(0, 9)), 1'($urandom), (N*M)'($urandom),
                (N*M)'($urandom), 2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
